inst_fetch_responder: RTL and testbench
=======================================

Name: inst_fetch_responder

Overview:
- Responder end of the instruction-fetch request interface, i.e. the req/addr_ok/double/data_ok/rdata protocol driven by the fetch unit.
- Sits between the i-side address translation output and a 32-bit single-word instruction memory bus.
- Accepts one fetch at a time and decides per request whether to deliver one or two instructions. For a two-instruction fetch it issues two sequential word reads, then returns a 64-bit packet with a one-cycle data_ok pulse.

Parameters:
- DUAL_EN, 1: 1 allows two-instruction (double) fetches; 0 forces every fetch to be single.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- inst_req  in  1  fetch request valid.
- inst_addr  in  32  physical fetch address, word aligned.
- inst_addr_ok  out  1  request accepted this cycle.
- inst_double  out  1  accepted request returns two instructions; valid whenever inst_req=1.
- inst_data_ok  out  1  one-cycle pulse: response data valid.
- inst_rdata  out  64  [31:0] word at addr; [63:32] word at addr+4 if double, else 0.
- mem_req  out  1  word read request.
- mem_addr  out  32  word read address.
- mem_addr_ok  in  1  memory accepted the read.
- mem_data_ok  in  1  read data valid.
- mem_rdata  in  32  read data.
- fetch_word_cnt  out  32  count of instruction words delivered via inst_data_ok.

Behaviour:
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP. Reset value is IDLE.
- Reset values: inst_data_ok=0, inst_rdata=0, mem_req=0, fetch_word_cnt=0, internal base/double registers = 0.
- inst_double is combinational: DUAL_EN && !inst_addr[2]. A pair never crosses an 8-byte boundary.
- inst_addr_ok is combinational: inst_req && (state==IDLE || state==RESP).
- On handshake (inst_req && inst_addr_ok):
  - latch base=inst_addr and dbl=inst_double;
  - next state is REQ0.
- REQ0:
  - mem_req=1, mem_addr=base;
  - on mem_addr_ok, go to WAIT0.
- WAIT0:
  - on mem_data_ok, latch word0 into rdata[31:0];
  - go to REQ1 if dbl, else go to RESP with rdata[63:32]=0.
- REQ1:
  - mem_req=1, mem_addr=base+4 (32-bit wrap);
  - on mem_addr_ok, go to WAIT1.
- WAIT1:
  - on mem_data_ok, latch word1 into rdata[63:32];
  - go to RESP.
- RESP:
  - inst_data_ok=1 for exactly this cycle;
  - fetch_word_cnt += (dbl ? 2 : 1), wrapping at 2^32;
  - if a new handshake occurs this same cycle, go to REQ0; otherwise go to IDLE.
- mem_req=0 in IDLE, WAIT0, WAIT1 and RESP. mem_addr is don't-care when mem_req=0 and is driven as base.
- Memory bus rules:
  - mem_data_ok arrives no earlier than the cycle after mem_addr_ok;
  - mem_data_ok is ignored in any state other than WAIT0/WAIT1;
  - mem_addr_ok is ignored when mem_req=0.
- inst_rdata holds its last value between responses; only the inst_data_ok cycle is meaningful.
- Exactly one inst_data_ok is returned per accepted request, in order. A request the requester has internally cancelled still receives its response. This block has no flush input.
- At most one request is outstanding. inst_addr_ok never asserts in REQ0..WAIT1.
- Minimum latency, handshake at cycle T:
  - single fetch: data_ok at T+3;
  - double fetch: data_ok at T+5.
- Back-to-back requests: a handshake accepted in the RESP cycle starts REQ0 next cycle with no idle bubble.
- Reset mid-operation returns to IDLE, drops the in-flight fetch, and clears the counter. The memory is reset with this block; stale mem_data_ok after reset is ignored in IDLE.
- Misaligned inst_addr[1:0] is not checked (filtered upstream). Bits [1:0] pass to mem_addr unchanged.

Test Plan:
- Single fetch: DUAL_EN=1, req addr=0x1c000004, memory returns 0x02800c0c with zero wait. Required: addr_ok=1 and double=0 at T; data_ok at T+3 with rdata=0x00000000_02800c0c; fetch_word_cnt=1.
- Double fetch: req addr=0x1c000000, memory words 0x11111111 then 0x22222222. Required: double=1 at T; mem_addr 0x1c000000 then 0x1c000004; data_ok at T+5 with rdata=0x22222222_11111111; counter +2.
- Back-to-back: hold req with addr 0x1c000008 across the RESP cycle of a previous fetch. Required: addr_ok=1 in the same cycle as data_ok; REQ0 next cycle with mem_addr=0x1c000008; no lost or duplicated data_ok.
- Memory stalls: mem_addr_ok delayed 3 cycles and mem_data_ok delayed 4 cycles on a double fetch. Required: mem_req held high with a stable mem_addr while stalled; inst_addr_ok=0 throughout; single data_ok with correct rdata.
- Reset mid-fetch: assert reset while in WAIT1, then pulse mem_data_ok after reset. Required: state IDLE, no inst_data_ok, fetch_word_cnt=0; next request handled normally.
- DUAL_EN=0: req addr=0x1c000000. Required: inst_double=0, one memory read only, data_ok at T+3, rdata[63:32]=0.

Source files
------------

// File: rtl/inst_fetch_responder.sv
// ---------------------------------------------------------------------------
// inst_fetch_responder : instruction-fetch responder that turns one or two
// word reads on a 32-bit memory bus into a 64-bit fetch packet.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_fetch_responder #(
   parameter bit DUAL_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_double,
   output logic        inst_data_ok,
   output logic [63:0] inst_rdata,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic [31:0] fetch_word_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ0  = 3'd1;
   localparam logic [2:0] S_WAIT0 = 3'd2;
   localparam logic [2:0] S_REQ1  = 3'd3;
   localparam logic [2:0] S_WAIT1 = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [31:0] base_q, base_d;
   logic        dbl_q, dbl_d;
   logic [63:0] rdata_q, rdata_d;
   logic [31:0] cnt_q, cnt_d;
   logic        accept;

   // A pair is only formed from the lower word of an 8-byte block.
   assign inst_double = DUAL_EN && !inst_addr[2];
   assign accept      = inst_req && inst_addr_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)      state_d = S_REQ0;
         S_REQ0:  if (mem_addr_ok) state_d = S_WAIT0;
         S_WAIT0: if (mem_data_ok) state_d = dbl_q ? S_REQ1 : S_RESP;
         S_REQ1:  if (mem_addr_ok) state_d = S_WAIT1;
         S_WAIT1: if (mem_data_ok) state_d = S_RESP;
         S_RESP:  state_d = accept ? S_REQ0 : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      inst_addr_ok = inst_req && ((state_q == S_IDLE) || (state_q == S_RESP));
      inst_data_ok = (state_q == S_RESP);
      mem_req      = (state_q == S_REQ0) || (state_q == S_REQ1);
      mem_addr     = (state_q == S_REQ1) ? (base_q + 32'd4) : base_q;
   end

   always_comb begin
      base_d  = base_q;
      dbl_d   = dbl_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      if (accept) begin
         base_d = inst_addr;
         dbl_d  = inst_double;
      end
      if ((state_q == S_WAIT0) && mem_data_ok) begin
         rdata_d[31:0] = mem_rdata;
         if (!dbl_q) rdata_d[63:32] = 32'd0;
      end
      if ((state_q == S_WAIT1) && mem_data_ok) begin
         rdata_d[63:32] = mem_rdata;
      end
      // Counter tracks the packet being returned, so it uses the old dbl_q.
      if (state_q == S_RESP) begin
         cnt_d = cnt_q + (dbl_q ? 32'd2 : 32'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q  <= 32'd0;
         dbl_q   <= 1'b0;
         rdata_q <= 64'd0;
         cnt_q   <= 32'd0;
      end else begin
         base_q  <= base_d;
         dbl_q   <= dbl_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign inst_rdata     = rdata_q;
   assign fetch_word_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_responder.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_responder : scoreboard bench for inst_fetch_responder.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_inst_fetch_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_double, inst_data_ok;
   logic [63:0] inst_rdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_addr_ok = 1'b0;
   logic        mem_data_ok = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic [31:0] fetch_word_cnt;

   logic        d0_req;
   logic [31:0] d0_addr;
   logic        d0_addr_ok, d0_double, d0_data_ok;
   logic [63:0] d0_rdata;
   logic        d0_mem_req;
   logic [31:0] d0_mem_addr;
   logic        d0_mem_addr_ok;
   logic        d0_mem_data_ok = 1'b0;
   logic [31:0] d0_mem_rdata = 32'd0;
   logic [31:0] d0_cnt;
   int          d0_reads = 0;

   always #5 clk = ~clk;

   inst_fetch_responder #(.DUAL_EN(1'b1)) u_dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_double(inst_double),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .fetch_word_cnt(fetch_word_cnt)
   );

   inst_fetch_responder #(.DUAL_EN(1'b0)) u_dut_single (
      .clk(clk), .reset(reset),
      .inst_req(d0_req), .inst_addr(d0_addr),
      .inst_addr_ok(d0_addr_ok), .inst_double(d0_double),
      .inst_data_ok(d0_data_ok), .inst_rdata(d0_rdata),
      .mem_req(d0_mem_req), .mem_addr(d0_mem_addr),
      .mem_addr_ok(d0_mem_addr_ok), .mem_data_ok(d0_mem_data_ok), .mem_rdata(d0_mem_rdata),
      .fetch_word_cnt(d0_cnt)
   );

   typedef struct {
      logic [63:0] data;
      int          due;
      int          nwords;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        exp0_q[$];
   logic [31:0] maddr_q[$];
   logic [31:0] mdata_q[$];
   logic [31:0] cnt_exp = 32'd0;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Memory model: programmable accept/data wait, checks every presented address.
   int          addr_wait = 0, data_wait = 0, acnt = 0, dcnt = 0;
   bit          pend = 0, stray = 0;
   logic [31:0] pdata = 32'd0;

   always @(negedge clk) begin
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (reset) begin
         pend = 0; acnt = 0; dcnt = 0;
      end else if (stray) begin
         mem_data_ok = 1'b1;
         mem_rdata   = 32'hdeadbeef;
         stray       = 0;
      end else if (pend) begin
         if (dcnt >= data_wait) begin
            mem_data_ok = 1'b1;
            mem_rdata   = pdata;
            pend = 0; dcnt = 0;
         end else begin
            dcnt++;
         end
      end else if (mem_req) begin
         if (maddr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_unexpected_req: got addr %h, expected no request", mem_addr);
         end else begin
            chk("mem_addr", {32'd0, mem_addr}, {32'd0, maddr_q[0]});
            if (acnt >= addr_wait) begin
               mem_addr_ok = 1'b1;
               pend  = 1; acnt = 0;
               pdata = mdata_q.pop_front();
               void'(maddr_q.pop_front());
            end else begin
               acnt++;
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (inst_data_ok) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_data_ok: got rdata %h, expected no response", inst_rdata);
         end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", inst_rdata, e.data);
            if (e.due >= 0) chk("resp_latency", 64'(cyc), 64'(e.due));
            cnt_exp = cnt_exp + 32'(e.nwords);
         end
      end else if (exp_q.size() != 0) begin
         chk("addr_ok_while_busy", {63'd0, inst_addr_ok}, 64'd0);
      end
   end

   // Zero-wait memory for the single-only instance.
   assign d0_mem_addr_ok = d0_mem_req;
   always @(posedge clk) begin
      d0_mem_data_ok <= d0_mem_req && !reset;
      d0_mem_rdata   <= 32'h0badf00d;
      if (d0_mem_req && !reset) d0_reads <= d0_reads + 1;
   end

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (d0_data_ok) begin
         if (exp0_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL d0_spurious_data_ok: got rdata %h, expected no response", d0_rdata);
         end else begin
            e = exp0_q.pop_front();
            chk("d0_rdata", d0_rdata, e.data);
            chk("d0_latency", 64'(cyc), 64'(e.due));
         end
      end
   end

   task automatic issue(input logic [31:0] addr, input bit dbl, input logic [31:0] w0,
                        input logic [31:0] w1, input int lat, input bit b2b);
      bit   ok;
      int   t;
      exp_t e;
      inst_req  = 1'b1;
      inst_addr = addr;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (inst_addr_ok) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got no inst_addr_ok, expected accept of %h", addr);
         inst_req = 1'b0;
         return;
      end
      chk("inst_double", {63'd0, inst_double}, {63'd0, dbl});
      if (b2b) chk("b2b_addr_ok_with_data_ok", {63'd0, inst_data_ok}, 64'd1);
      t = cyc;
      @(posedge clk);
      #1;
      e.data   = dbl ? {w1, w0} : {32'd0, w0};
      e.due    = (lat < 0) ? -1 : t + lat;
      e.nwords = dbl ? 2 : 1;
      exp_q.push_back(e);
      maddr_q.push_back(addr);
      mdata_q.push_back(w0);
      if (dbl) begin
         maddr_q.push_back(addr + 32'd4);
         mdata_q.push_back(w1);
      end
   endtask

   task automatic wait_done();
      bit done;
      done = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #3;
         if (exp_q.size() == 0) begin done = 1; break; end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL response_timeout: got %0d pending, expected 0", exp_q.size());
      end
      @(negedge clk);
      #3;
      chk("fetch_word_cnt", {32'd0, fetch_word_cnt}, {32'd0, cnt_exp});
   endtask

   initial begin
      bit done;
      int t;
      exp_t e;
      reset = 1'b1; inst_req = 1'b0; inst_addr = 32'd0;
      d0_req = 1'b0; d0_addr = 32'd0;
      repeat (3) @(negedge clk);
      #3;
      chk("rst_data_ok", {63'd0, inst_data_ok}, 64'd0);
      chk("rst_rdata", inst_rdata, 64'd0);
      chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
      chk("rst_cnt", {32'd0, fetch_word_cnt}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      issue(32'h1c000004, 1'b0, 32'h02800c0c, 32'd0, 3, 1'b0);
      inst_req = 1'b0;
      wait_done();

      issue(32'h1c000000, 1'b1, 32'h11111111, 32'h22222222, 5, 1'b0);
      inst_req = 1'b0;
      wait_done();

      issue(32'h1c000014, 1'b0, 32'h33333333, 32'd0, 3, 1'b0);
      issue(32'h1c000008, 1'b1, 32'h44444444, 32'h55555555, 5, 1'b1);
      inst_req = 1'b0;
      wait_done();

      addr_wait = 3; data_wait = 4;
      issue(32'h1c000020, 1'b1, 32'h66666666, 32'h77777777, -1, 1'b0);
      inst_req = 1'b0;
      wait_done();
      addr_wait = 0;

      // Long first-word wait puts the second word's WAIT1 around T+10..T+15.
      data_wait = 6;
      issue(32'h1c000030, 1'b1, 32'h99999999, 32'haaaaaaaa, -1, 1'b0);
      inst_req = 1'b0;
      repeat (11) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_q.delete(); maddr_q.delete(); mdata_q.delete();
      cnt_exp = 32'd0;
      @(negedge clk);
      reset = 1'b0; data_wait = 0;
      @(negedge clk);
      stray = 1;
      repeat (3) @(negedge clk);
      #3;
      chk("post_rst_cnt", {32'd0, fetch_word_cnt}, 64'd0);
      chk("post_rst_mem_req", {63'd0, mem_req}, 64'd0);
      issue(32'h1c000044, 1'b0, 32'h88888888, 32'd0, 3, 1'b0);
      inst_req = 1'b0;
      wait_done();

      @(negedge clk);
      d0_req = 1'b1; d0_addr = 32'h1c000000;
      #1;
      chk("d0_addr_ok", {63'd0, d0_addr_ok}, 64'd1);
      chk("d0_double", {63'd0, d0_double}, 64'd0);
      t = cyc;
      e.data = 64'h00000000_0badf00d; e.due = t + 3; e.nwords = 1;
      exp0_q.push_back(e);
      @(posedge clk);
      #1;
      d0_req = 1'b0;
      done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #3;
         if (exp0_q.size() == 0) begin done = 1; break; end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL d0_timeout: got no data_ok, expected one response");
      end
      @(negedge clk);
      #3;
      chk("d0_mem_reads", 64'(d0_reads), 64'd1);
      chk("d0_cnt", {32'd0, d0_cnt}, 64'd1);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
